// File: rtl/std_binary_decoder.sv
// Binary-to-one-hot decoder with enable, plus a registered copy for wide fan-out.
// Optional concurrent checks are compiled in with STD_BINARY_DECODER_ASSERT_EN.
module std_binary_decoder #(
  parameter int BIN_WIDTH = 8,
  localparam int UNARY_WIDTH = 1 << BIN_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [BIN_WIDTH-1:0]   i_bin,
  output logic [UNARY_WIDTH-1:0] o_unary,
  output logic [UNARY_WIDTH-1:0] o_unary_q,
  output logic                   o_en_q
);

  // One comparator per output line; an X on i_bin yields X lines rather than a masked zero.
  for (genvar k = 0; k < UNARY_WIDTH; k++) begin : g_line
    assign o_unary[k] = i_en & (i_bin == BIN_WIDTH'(k));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_unary_q <= '0;
      o_en_q    <= 1'b0;
    end else begin
      o_unary_q <= o_unary;
      o_en_q    <= i_en;
    end
  end

`ifdef STD_BINARY_DECODER_ASSERT_EN
  a_unary_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    i_en |-> ($onehot(o_unary) && o_unary[i_bin]))
    else $error("o_unary: not one-hot at index i_bin while i_en=1");

  a_unary_zero: assert property (@(posedge i_clk) disable iff (i_rst)
    !i_en |-> (o_unary == '0))
    else $error("o_unary: nonzero while i_en=0");

  a_unary_q_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    o_en_q |-> $onehot(o_unary_q))
    else $error("o_unary_q: not one-hot while o_en_q=1");
`else
`endif

endmodule

// File: tb/tb_std_binary_decoder.sv
// Directed bench for std_binary_decoder: 8-bit sweep, enable gating, reset behaviour, 1-bit build.
module tb_std_binary_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [7:0]   bin;
  logic [255:0] unary, unary_q;
  logic         en_q;

  logic         en1;
  logic [0:0]   bin1;
  logic [1:0]   unary1, unary1_q;
  logic         en1_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  std_binary_decoder #(.BIN_WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_bin(bin),
    .o_unary(unary), .o_unary_q(unary_q), .o_en_q(en_q)
  );

  std_binary_decoder #(.BIN_WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en1), .i_bin(bin1),
    .o_unary(unary1), .o_unary_q(unary1_q), .o_en_q(en1_q)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [255:0] one;
    logic [255:0] exp_q;
    logic         exp_en;
    one  = 256'd1;
    rst  = 1'b1;
    en   = 1'b0;
    bin  = 8'h00;
    en1  = 1'b0;
    bin1 = 1'b0;
    #1;
    chk("reset_unary_q", unary_q, '0);
    chk("reset_en_q", {255'd0, en_q}, '0);

    // Full sweep while reset is held: combinational path must ignore reset.
    en = 1'b1;
    for (int b = 0; b < 256; b++) begin
      bin = 8'(b);
      #1;
      chk($sformatf("sweep_%0d", b), unary, one << b);
    end
    chk("sweep_q_held", unary_q, '0);

    en = 1'b0; bin = 8'h5A; #1;
    chk("disabled_5a", unary, '0);
    en = 1'b1; #1;
    chk("enabled_5a", unary, one << 90);

    // Clock edge during reset must not capture.
    en = 1'b1; bin = 8'd3;
    @(posedge clk); #1;
    chk("rst_edge_q", unary_q, '0);
    chk("rst_edge_en_q", {255'd0, en_q}, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("first_capture_q", unary_q, one << 3);
    chk("first_capture_en_q", {255'd0, en_q}, 256'd1);

    // Asynchronous reset between edges.
    @(negedge clk); rst = 1'b1; #1;
    chk("async_rst_q", unary_q, '0);
    chk("async_rst_en_q", {255'd0, en_q}, '0);
    chk("async_rst_comb", unary, one << 3);
    @(posedge clk); #1;
    chk("rst_hold_q", unary_q, '0);
    @(negedge clk); rst = 1'b0; en = 1'b0; bin = 8'd7;
    @(posedge clk); #1;
    chk("disabled_capture_q", unary_q, '0);
    chk("disabled_capture_en_q", {255'd0, en_q}, '0);
    @(negedge clk); en = 1'b1; bin = 8'd200;
    @(posedge clk); #1;
    chk("capture_200_q", unary_q, one << 200);
    chk("capture_200_en_q", {255'd0, en_q}, 256'd1);

    // Random enable/code sequence through the registered path.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      en  = 1'($urandom_range(0, 1));
      bin = 8'($urandom_range(0, 255));
      exp_en = en;
      exp_q  = en ? (one << bin) : '0;
      #1;
      chk($sformatf("rand_comb_%0d", i), unary, exp_q);
      @(posedge clk); #1;
      chk($sformatf("rand_q_%0d", i), unary_q, exp_q);
      chk($sformatf("rand_en_q_%0d", i), {255'd0, en_q}, {255'd0, exp_en});
    end

    // 1-bit instance.
    en1 = 1'b1; bin1 = 1'b0; #1;
    chk("w1_bin0", {254'd0, unary1}, 256'd1);
    bin1 = 1'b1; #1;
    chk("w1_bin1", {254'd0, unary1}, 256'd2);
    en1 = 1'b0; #1;
    chk("w1_disabled", {254'd0, unary1}, 256'd0);
    @(negedge clk); en1 = 1'b1; bin1 = 1'b1;
    @(posedge clk); #1;
    chk("w1_q", {254'd0, unary1_q}, 256'd2);
    chk("w1_en_q", {255'd0, en1_q}, 256'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
